// File: rtl/ctrl_unit_top.sv
// rtl/ctrl_unit_top.sv - microprogrammed control-unit sequencer (optional stall via CTRL_UNIT_STALL_EN)
module ctrl_unit_top #(
    parameter int         AW          = 5,
    parameter logic [4:0] FETCH1_ADDR = 5'd0,
    parameter logic [4:0] MAP_BASE    = 5'd2,
    parameter logic [3:0] JMPNZ_OPC   = 4'h5,
    parameter logic [4:0] JMPNZN_ADDR = 5'd18
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          br,
    input  logic          z,
    input  logic [7:0]    ir,
    input  logic [AW-1:0] na,
`ifdef CTRL_UNIT_STALL_EN
    input  logic          stall,
`endif
    output logic [AW+31:0] out
);

    logic [AW-1:0] upc;
    logic [AW-1:0] upc_next;
    logic [AW-1:0] map_addr;
    logic [3:0]    opcode;
    logic          unused_ir_low;

    assign opcode        = ir[7:4];
    assign unused_ir_low = ^ir[3:0];
    assign map_addr      = MAP_BASE + {{(AW-4){1'b0}}, opcode};

    // br is tested first so an undriven na never reaches upc while mapping
    always_comb begin
        upc_next = upc;
        if (!br) begin
            upc_next = na;
        end else if (opcode == JMPNZ_OPC) begin
            upc_next = z ? JMPNZN_ADDR : map_addr;
        end else begin
            upc_next = map_addr;
        end
`ifdef CTRL_UNIT_STALL_EN
        if (stall) begin
            upc_next = upc;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upc <= FETCH1_ADDR;
        end else begin
            upc <= upc_next;
        end
    end

    assign out = {upc, 32'd1 << upc};

endmodule

// File: tb/tb_ctrl_unit_top.sv
// tb/tb_ctrl_unit_top.sv - scoreboard bench for ctrl_unit_top
module tb_ctrl_unit_top;

    logic        clk;
    logic        rst_n;
    logic        br;
    logic        z;
    logic [7:0]  ir;
    logic [4:0]  na;
    logic        stall;
    logic [36:0] out;

    int vectors;
    int miscompares;
    logic [36:0] sb[$];
    logic [4:0]  m_upc;

    ctrl_unit_top dut (
        .clk   (clk),
        .rst_n (rst_n),
        .br    (br),
        .z     (z),
        .ir    (ir),
        .na    (na),
`ifdef CTRL_UNIT_STALL_EN
        .stall (stall),
`endif
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [36:0] word_of(input logic [4:0] a);
        logic [31:0] oh;
        oh = 32'h0;
        oh[a] = 1'b1;
        return {a, oh};
    endfunction

    // Reference next-address rule, written from the address map
    function automatic logic [4:0] ref_next(input logic [4:0] cur, input logic b,
                                            input logic [7:0] i, input logic zz,
                                            input logic [4:0] n, input logic s);
        if (s) return cur;
        if (!b) return n;
        if (i[7:4] == 4'h5) return zz ? 5'd18 : 5'd7;
        return 5'd2 + {1'b0, i[7:4]};
    endfunction

    task automatic apply(input logic b, input logic [7:0] i, input logic zz,
                         input logic [4:0] n, input logic s);
        @(negedge clk);
        br = b; ir = i; z = zz; na = n; stall = s;
        m_upc = ref_next(m_upc, b, i, zz, n, s);
        sb.push_back(word_of(m_upc));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [36:0] e;
        rst_n = 1'b0; br = 1'b0; z = 1'b0; ir = 8'h00; na = 5'd0; stall = 1'b0;
        m_upc = 5'd0;
        #12;
        vectors++;
        if (out !== 37'h00_0000_0001) begin
            miscompares++;
            $display("FAIL reset_hold out=%h expected=%h", out, 37'h00_0000_0001);
        end
        @(negedge clk);
        rst_n = 1'b1;
        apply(1'b0, 8'h00, 1'b0, 5'd13, 1'b0);
        e = sb.pop_front();
        vectors++;
        if (out !== e) begin
            miscompares++;
            $display("FAIL reset_pre13 out=%h expected=%h", out, e);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        m_upc = 5'd0;
        #1;
        vectors++;
        if (out !== 37'h00_0000_0001) begin
            miscompares++;
            $display("FAIL reset_async out=%h expected=%h", out, 37'h00_0000_0001);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        apply(1'b0, 8'h00, 1'b0, 5'd1, 1'b0);
        e = sb.pop_front();
        vectors++;
        if (out !== {5'd1, 32'h0000_0002}) begin
            miscompares++;
            $display("FAIL reset_release out=%h expected=%h", out, {5'd1, 32'h0000_0002});
        end
    endtask

    task automatic test_load();
        logic [36:0] e;
        logic        b_t[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [7:0]  ir_t[6] = '{8'h00, 8'h00, 8'hB0, 8'h00, 8'h00, 8'h00};
        logic [4:0]  na_t[6] = '{5'd0, 5'd1, 5'bxxxxx, 5'd22, 5'd23, 5'd0};
        for (int k = 0; k < 6; k++) begin
            apply(b_t[k], ir_t[k], 1'b0, na_t[k], 1'b0);
            e = sb.pop_front();
            vectors++;
            if (out !== e) begin
                miscompares++;
                $display("FAIL load_step%0d out=%h expected=%h", k, out, e);
            end
        end
    endtask

    task automatic test_sub();
        logic [36:0] e;
        apply(1'b1, 8'h40, 1'b0, 5'bxxxxx, 1'b0);
        e = sb.pop_front();
        vectors++;
        if (out !== {5'd6, 32'h0000_0040}) begin
            miscompares++;
            $display("FAIL sub_map out=%h expected=%h", out, {5'd6, 32'h0000_0040});
        end
        apply(1'b0, 8'h40, 1'b0, 5'd0, 1'b0);
        e = sb.pop_front();
        vectors++;
        if (out !== e) begin
            miscompares++;
            $display("FAIL sub_return out=%h expected=%h", out, e);
        end
    endtask

    task automatic test_jmpnz();
        logic [36:0] e;
        logic        b_t[3]  = '{1'b1, 1'b1, 1'b0};
        logic        z_t[3]  = '{1'b0, 1'b1, 1'b1};
        logic [4:0]  na_t[3] = '{5'd9, 5'd9, 5'd11};
        for (int k = 0; k < 3; k++) begin
            apply(b_t[k], 8'h50, z_t[k], na_t[k], 1'b0);
            e = sb.pop_front();
            vectors++;
            if (out !== e) begin
                miscompares++;
                $display("FAIL jmpnz_step%0d out=%h expected=%h", k, out, e);
            end
        end
    endtask

    task automatic test_map_ignores();
        logic [36:0] e;
        logic [7:0]  ir_t[4] = '{8'h00, 8'hD0, 8'hA0, 8'hFF};
        logic        z_t[4]  = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [4:0]  na_t[4] = '{5'd31, 5'd4, 5'd4, 5'bzzzzz};
        for (int k = 0; k < 4; k++) begin
            apply(1'b1, ir_t[k], z_t[k], na_t[k], 1'b0);
            e = sb.pop_front();
            vectors++;
            if (out !== e) begin
                miscompares++;
                $display("FAIL map_step%0d out=%h expected=%h", k, out, e);
            end
        end
        apply(1'b0, 8'h5F, 1'bx, 5'd31, 1'b0);
        e = sb.pop_front();
        vectors++;
        if (out !== {5'd31, 32'h8000_0000}) begin
            miscompares++;
            $display("FAIL na_max out=%h expected=%h", out, {5'd31, 32'h8000_0000});
        end
    endtask

    task automatic test_back_to_back();
        logic [36:0] e;
        logic        b;
        logic [4:0]  n;
        for (int k = 0; k < 48; k++) begin
            b = 1'($urandom_range(0, 1));
            n = (b && (k % 3 == 0)) ? 5'bxxxxx : 5'($urandom_range(0, 31));
            apply(b, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), n, 1'b0);
            e = sb.pop_front();
            vectors++;
            if (out !== e) begin
                miscompares++;
                $display("FAIL b2b_step%0d out=%h expected=%h", k, out, e);
            end
        end
    endtask

`ifdef CTRL_UNIT_STALL_EN
    task automatic test_stall();
        logic [36:0] e;
        logic       s_t[4]  = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic       b_t[4]  = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic [4:0] na_t[4] = '{5'bxxxxx, 5'd22, 5'd22, 5'd22};
        for (int k = 0; k < 4; k++) begin
            apply(b_t[k], 8'hB0, 1'b0, na_t[k], s_t[k]);
            e = sb.pop_front();
            vectors++;
            if (out !== e) begin
                miscompares++;
                $display("FAIL stall_step%0d out=%h expected=%h", k, out, e);
            end
        end
        @(negedge clk);
        stall = 1'b1;
        rst_n = 1'b0;
        m_upc = 5'd0;
        #1;
        vectors++;
        if (out !== 37'h00_0000_0001) begin
            miscompares++;
            $display("FAIL stall_reset out=%h expected=%h", out, 37'h00_0000_0001);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        stall = 1'b0;
    endtask
`endif

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_load();
        test_sub();
        test_jmpnz();
        test_map_ignores();
        test_back_to_back();
`ifdef CTRL_UNIT_STALL_EN
        test_stall();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ctrl_unit_top.md
Name: ctrl_unit_top

Overview:
- Microprogrammed control-unit sequencer for the single-accumulator CPU.
- Holds a 5-bit micro-program counter (upc) and each clock selects the next micro-address:
  - br=0: the explicit next-address field na.
  - br=1: an opcode-mapped address from ir, plus z for JMPNZ.
- Drives a 37-bit control word decoded from the current micro-address to the datapath.
- Sits between the instruction register / ALU flag and the datapath control inputs.

Parameters:
- AW, 5: micro-address width; fixed, 32 micro-states.
- FETCH1_ADDR, 5'd0: reset and fetch entry address.
- MAP_BASE, 5'd2: base of the opcode map region.
- JMPNZ_OPC, 4'h5: opcode (ir[7:4]) of JMPNZ.
- JMPNZN_ADDR, 5'd18: address taken for JMPNZ when z=1 (no jump).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- br  in  1  branch/map select (1 = use opcode map, 0 = use na).
- z  in  1  accumulator-zero flag from the ALU.
- ir  in  8  instruction register; opcode is ir[7:4], ir[3:0] is ignored.
- na  in  5  next micro-address field of the current microinstruction.
- out  out  37  control word.

Behaviour:
- Reset:
  - rst_n low forces upc=FETCH1_ADDR (0) immediately, independent of clk.
  - out therefore equals {5'd0, 32'h0000_0001} during reset and on its release.
- Next-address selection, evaluated combinationally and loaded into upc on each rising clk edge while rst_n=1:
  - br=0: next = na.
  - br=1 and ir[7:4]!=JMPNZ_OPC: next = MAP_BASE + {1'b0, ir[7:4]}, i.e. opcodes 0x0..0xF map to addresses 2..17. z is ignored.
  - br=1, ir[7:4]==JMPNZ_OPC, z=0: next = MAP_BASE+5 = 7 (JMPNZY1, jump taken).
  - br=1, ir[7:4]==JMPNZ_OPC, z=1: next = JMPNZN_ADDR = 18 (JMPNZN1).
- Input masking:
  - When br=1, na is fully ignored, including X/Z values; X on na must not propagate into upc.
  - When br=0, ir and z are ignored.
- Micro-address map:
  - 0 = FETCH1, 1 = FETCH2.
  - 2..17 = first microinstruction of each opcode; LOAD (0xB) = 13, SUB (0x4) = 6, JMPNZ taken = 7.
  - 18 = JMPNZN1.
  - 19..31 = continuation words, reached only through na.
- Control word, combinational from upc with zero additional latency:
  - out[36:32] = upc.
  - out[31:0] = one-hot of upc (bit k set iff upc==k).
  - A new micro-state is visible on out immediately after the clock edge that loads it.
- Arithmetic: the map addition is 5-bit with no overflow possible (max 17). na accepts any value 0..31.
- Simultaneous events: reset assertion overrides any clock edge. On the first rising edge after rst_n deasserts, normal selection applies.
- No other state; no handshake.

Optional Feature:
- CTRL_UNIT_STALL_EN defined:
  - Adds input port stall (1 bit, placed after na).
  - stall=1 holds upc at its current value on the clock edge regardless of br/na/ir/z.
  - Reset still overrides stall.
- CTRL_UNIT_STALL_EN undefined: no stall port; upc updates on every edge as above.

Test Plan:
- Reset: rst_n=0 mid-cycle with upc=13 -> upc=0 immediately, out=37'h00_0000_0001. Release, then br=0 na=1 on the next edge -> out={5'd1,32'h0000_0002}.
- LOAD sequence:
  - Fetch 0->1.
  - br=1 ir=8'hB0 na=5'bxxxxx -> upc=13, out={5'd13,32'h0000_2000}.
  - br=0 na=22 -> 22; na=23 -> 23; na=0 -> 0.
- SUB: br=1 ir=8'h40 na=X -> upc=6, out={5'd6,32'h0000_0040}. Then br=0 na=0 -> 0.
- JMPNZ:
  - br=1 ir=8'h50 z=0 -> upc=7.
  - br=1 ir=8'h50 z=1 -> upc=18.
  - br=0 na=11 z=1 -> upc=11.
- Map ignores na and z:
  - br=1 ir=8'h00 z=1 -> upc=2.
  - br=1 ir=8'hD0 na=4 -> upc=15.
  - br=1 ir=8'hA0 na=4 z=0 -> upc=12.
- Stall, with CTRL_UNIT_STALL_EN: upc=13, stall=1, br=0 na=22 for two edges -> upc stays 13. Deassert stall -> upc=22.
